ram_param: RTL and testbench



---
 rtl/ram_param_pkg.sv | 26 ++
 rtl/ram_clear_seq.sv | 60 ++++++
 rtl/ram_param.sv | 88 ++++++++
 tb/tb_ram_param.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/ram_param_pkg.sv
// Shared definitions for the parametrised data RAM: clear-sequencer state
// encoding, a constant clog2 helper and the default datapath geometry.
package ram_param_pkg;

  // Default geometry: the 64-byte data RAM this block replaces.
  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned ADDR_W_DEF = 8;
  localparam int unsigned DEPTH_DEF  = 64;

  // Clear sequencer states; busy is exactly (state == ST_CLEAR).
  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_t;

  // Ceiling log2 for elaboration-time width calculations.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/ram_clear_seq.sv
// Clear sequencer: walks clr_ptr over 0..DEPTH-1 after reset or a clear
// request, one entry per cycle, and reports busy while sweeping.
// Ports:
//   clk, reset    clock, synchronous active-high reset
//   clear_req     one-cycle request to start a sweep (honoured in idle)
//   busy          high while the sweep runs
//   clr_we        array write enable for the zeroing write
//   clr_addr      entry being zeroed this cycle
module ram_clear_seq
  import ram_param_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEF,
  localparam int unsigned PTR_W = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear_req,
  output logic             busy,
  output logic             clr_we,
  output logic [PTR_W-1:0] clr_addr
);

  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

  clr_state_t       state;
  logic [PTR_W-1:0] clr_ptr;

  // Sweep FSM; the pointer parks at 0 so it never runs past DEPTH-1.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_CLEAR;
      clr_ptr <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          clr_ptr <= '0;
          if (clear_req) state <= ST_CLEAR;
        end
        ST_CLEAR: begin
          if (clr_ptr == LAST) begin
            state   <= ST_IDLE;
            clr_ptr <= '0;
          end else begin
            clr_ptr <= clr_ptr + PTR_W'(1);
          end
        end
        default: begin
          state   <= ST_IDLE;
          clr_ptr <= '0;
        end
      endcase
    end
  end

  assign busy     = (state == ST_CLEAR);
  // The reset edge itself does not zero an entry; the sweep restarts at 0.
  assign clr_we   = busy & ~reset;
  assign clr_addr = clr_ptr;

endmodule

// File: rtl/ram_param.sv
// Parametrised single-port synchronous data RAM with byte strobes,
// registered read + valid, out-of-range error pulse and a hardware clear.
// Ports:
//   clk, reset     clock, synchronous active-high reset (starts a clear)
//   mem_write      write request; write_strb selects byte lanes
//   mem_read       read request; data appears next cycle with read_valid
//   address        word address, checked against DEPTH on all ADDR_W bits
//   write_data     write data
//   write_strb     byte-lane enables
//   clear_req      one-cycle request to zero the whole array
//   mem_data_out   registered read data (0 when not reading)
//   read_valid     high the cycle after an accepted read
//   addr_err       one-cycle pulse after an access with address >= DEPTH
//   busy           clear sweep in progress; accesses are ignored
// DATA_W must be a multiple of 8 and 1 < DEPTH <= 2**ADDR_W.
module ram_param
  import ram_param_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                mem_write,
  input  logic                mem_read,
  input  logic [ADDR_W-1:0]   address,
  input  logic [DATA_W-1:0]   write_data,
  input  logic [DATA_W/8-1:0] write_strb,
  input  logic                clear_req,
  output logic [DATA_W-1:0]   mem_data_out,
  output logic                read_valid,
  output logic                addr_err,
  output logic                busy
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned IDX_W  = clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  logic             clr_we;
  logic [IDX_W-1:0] clr_addr;
  logic             in_range_c;
  logic             accept_c;
  logic [IDX_W-1:0] idx_c;

  ram_clear_seq #(
    .DEPTH (DEPTH)
  ) u_clear_seq (
    .clk       (clk),
    .reset     (reset),
    .clear_req (clear_req),
    .busy      (busy),
    .clr_we    (clr_we),
    .clr_addr  (clr_addr)
  );

  // One extra bit so DEPTH == 2**ADDR_W still compares correctly.
  assign in_range_c = ({1'b0, address} < (ADDR_W + 1)'(DEPTH));
  assign accept_c   = ~busy & ~reset;
  assign idx_c      = address[IDX_W-1:0];

  // Array: sweep writes take priority; accesses are blocked while busy.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_addr] <= '0;
    end else if (accept_c && mem_write && in_range_c) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (write_strb[i]) mem[idx_c][8*i +: 8] <= write_data[8*i +: 8];
      end
    end
  end

  // Registered read port; sampling mem here gives read-before-write.
  always_ff @(posedge clk) begin
    if (reset || busy) begin
      mem_data_out <= '0;
      read_valid   <= 1'b0;
      addr_err     <= 1'b0;
    end else begin
      read_valid   <= mem_read;
      mem_data_out <= (mem_read && in_range_c) ? mem[idx_c] : '0;
      addr_err     <= (mem_read | mem_write) & ~in_range_c;
    end
  end

endmodule

// File: tb/tb_ram_param.sv
module tb_ram_param;

  localparam int DW = 16;
  localparam int AW = 8;
  localparam int DP = 64;

  logic          clk;
  logic          reset;
  logic          mem_write;
  logic          mem_read;
  logic [AW-1:0] address;
  logic [DW-1:0] write_data;
  logic [1:0]    write_strb;
  logic          clear_req;
  logic [DW-1:0] mem_data_out;
  logic          read_valid;
  logic          addr_err;
  logic          busy;

  ram_param #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DP)) dut (
    .clk          (clk),
    .reset        (reset),
    .mem_write    (mem_write),
    .mem_read     (mem_read),
    .address      (address),
    .write_data   (write_data),
    .write_strb   (write_strb),
    .clear_req    (clear_req),
    .mem_data_out (mem_data_out),
    .read_valid   (read_valid),
    .addr_err     (addr_err),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    logic          valid;
    logic          err;
    logic          bsy;
  } exp_t;

  typedef struct {
    logic          wr;
    logic          rd;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [1:0]    strb;
    logic [DW-1:0] x_data;
    logic          x_valid;
    logic          x_err;
  } vec_t;

  exp_t          sb[$];
  logic [DW-1:0] ref_mem [DP];
  logic          m_busy;
  int            m_left;
  int            total;
  int            bad;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Drive one cycle, predict the registered outputs, compare after the edge.
  task automatic apply(input logic wr, input logic rd, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [1:0] s,
                       input logic clr, input logic rst);
    exp_t e;
    logic inr;
    inr = (a < AW'(DP));
    e.data = '0; e.valid = 1'b0; e.err = 1'b0;
    if (rst) begin
      m_busy = 1'b1;
      m_left = DP;
    end else if (m_busy) begin
      ref_mem[DP - m_left] = '0;
      m_left--;
      if (m_left == 0) m_busy = 1'b0;
    end else begin
      e.valid = rd;
      e.data  = (rd && inr) ? ref_mem[a[5:0]] : '0;
      e.err   = (rd || wr) && !inr;
      if (wr && inr) begin
        if (s[0]) ref_mem[a[5:0]][7:0]  = d[7:0];
        if (s[1]) ref_mem[a[5:0]][15:8] = d[15:8];
      end
      if (clr) begin
        m_busy = 1'b1;
        m_left = DP;
      end
    end
    e.bsy = m_busy;
    sb.push_back(e);
    mem_write = wr; mem_read = rd; address = a; write_data = d;
    write_strb = s; clear_req = clr; reset = rst;
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("data", 32'(mem_data_out), 32'(e.data));
    chk("valid", 32'(read_valid), 32'(e.valid));
    chk("err", 32'(addr_err), 32'(e.err));
    chk("busy", 32'(busy), 32'(e.bsy));
  endtask

  // Step while busy (bounded), counting busy cycles; access inputs held.
  task automatic run_busy(input logic wr, input logic rd, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, output int n);
    n = 0;
    for (int i = 0; i < 200 && busy === 1'b1; i++) begin
      n++;
      apply(wr, rd, a, d, 2'b11, 1'b0, 1'b0);
    end
    chk("sweep_ends", 32'(busy), 32'd0);
  endtask

  vec_t vecs[15];
  int   n;
  logic found;

  initial begin
    total = 0; bad = 0;
    m_busy = 1'b0; m_left = 0;
    for (int i = 0; i < DP; i++) ref_mem[i] = '0;

    vecs[0]  = '{1'b1, 1'b0, 8'd5,   16'h1234, 2'b11, 16'h0000, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 8'd5,   16'hAB00, 2'b10, 16'h0000, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 8'd5,   16'h0000, 2'b00, 16'hAB34, 1'b1, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 8'd9,   16'h0001, 2'b11, 16'h0000, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 1'b1, 8'd9,   16'h0002, 2'b11, 16'h0001, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 8'd9,   16'h0000, 2'b00, 16'h0002, 1'b1, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 8'd64,  16'hFFFF, 2'b11, 16'h0000, 1'b0, 1'b1};
    vecs[7]  = '{1'b0, 1'b0, 8'd0,   16'h0000, 2'b00, 16'h0000, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 8'd200, 16'h0000, 2'b00, 16'h0000, 1'b1, 1'b1};
    vecs[9]  = '{1'b0, 1'b1, 8'd63,  16'h0000, 2'b00, 16'h0000, 1'b1, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 8'd10,  16'h5555, 2'b00, 16'h0000, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 8'd10,  16'h0000, 2'b00, 16'h0000, 1'b1, 1'b0};
    vecs[12] = '{1'b1, 1'b0, 8'd62,  16'hBEEF, 2'b11, 16'h0000, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 1'b1, 8'd62,  16'h0000, 2'b00, 16'hBEEF, 1'b1, 1'b0};
    vecs[14] = '{1'b1, 1'b1, 8'd255, 16'h1111, 2'b11, 16'h0000, 1'b1, 1'b1};

    // Power-up reset and initial sweep
    apply(1'b0, 1'b0, 8'd0, 16'h0, 2'b00, 1'b0, 1'b1);
    chk("reset_busy", 32'(busy), 32'd1);
    run_busy(1'b0, 1'b0, 8'd0, 16'h0, n);
    chk("init_sweep_len", 32'(n), 32'd64);

    // Reset sweep zeroes first and last entries
    apply(1'b1, 1'b0, 8'd0,  16'hBEEF, 2'b11, 1'b0, 1'b0);
    apply(1'b1, 1'b0, 8'd63, 16'hBEEF, 2'b11, 1'b0, 1'b0);
    apply(1'b0, 1'b1, 8'd63, 16'h0, 2'b00, 1'b0, 1'b0);
    chk("pre_reset_63", 32'(mem_data_out), 32'hBEEF);
    apply(1'b0, 1'b0, 8'd0, 16'h0, 2'b00, 1'b0, 1'b1);
    run_busy(1'b0, 1'b0, 8'd0, 16'h0, n);
    chk("reset_sweep_len", 32'(n), 32'd64);
    apply(1'b0, 1'b1, 8'd0, 16'h0, 2'b00, 1'b0, 1'b0);
    chk("rst_rd0_data", 32'(mem_data_out), 32'h0);
    chk("rst_rd0_valid", 32'(read_valid), 32'd1);
    apply(1'b0, 1'b1, 8'd63, 16'h0, 2'b00, 1'b0, 1'b0);
    chk("rst_rd63_data", 32'(mem_data_out), 32'h0);
    chk("rst_rd63_valid", 32'(read_valid), 32'd1);

    // Table: strobes, read-before-write, out of range, no-op strobe
    for (int i = 0; i < 15; i++) begin
      apply(vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].data, vecs[i].strb, 1'b0, 1'b0);
      chk($sformatf("vec%0d_data", i), 32'(mem_data_out), 32'(vecs[i].x_data));
      chk($sformatf("vec%0d_valid", i), 32'(read_valid), 32'(vecs[i].x_valid));
      chk($sformatf("vec%0d_err", i), 32'(addr_err), 32'(vecs[i].x_err));
    end

    // Out-of-range writes must not have touched the array
    found = 1'b0;
    for (int a = 0; a < DP; a++) begin
      apply(1'b0, 1'b1, AW'(a), 16'h0, 2'b00, 1'b0, 1'b0);
      if (mem_data_out === 16'hFFFF || mem_data_out === 16'h1111) found = 1'b1;
    end
    chk("scan_no_oor_data", 32'(found), 32'd0);

    // Clear request alongside a write; writes during busy dropped
    apply(1'b1, 1'b0, 8'd3, 16'h00AA, 2'b11, 1'b1, 1'b0);
    chk("clr_busy_rise", 32'(busy), 32'd1);
    run_busy(1'b1, 1'b0, 8'd3, 16'hFFFF, n);
    chk("clr_sweep_len", 32'(n), 32'd64);
    apply(1'b0, 1'b1, 8'd3, 16'h0, 2'b00, 1'b0, 1'b0);
    chk("clr_rd3_data", 32'(mem_data_out), 32'h0);
    chk("clr_rd3_valid", 32'(read_valid), 32'd1);

    // Reset 10 cycles into a clear restarts the full sweep
    apply(1'b1, 1'b0, 8'd7, 16'h7777, 2'b11, 1'b0, 1'b0);
    apply(1'b0, 1'b0, 8'd0, 16'h0, 2'b00, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) apply(1'b0, 1'b1, 8'd7, 16'h0, 2'b00, 1'b0, 1'b0);
    apply(1'b0, 1'b1, 8'd7, 16'h0, 2'b00, 1'b0, 1'b1);
    run_busy(1'b0, 1'b1, 8'd7, 16'h0, n);
    chk("midsweep_len", 32'(n), 32'd64);
    apply(1'b0, 1'b1, 8'd7, 16'h0, 2'b00, 1'b0, 1'b0);
    chk("midsweep_rd7", 32'(mem_data_out), 32'h0);
    chk("midsweep_rd7_valid", 32'(read_valid), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
